// File: rtl/traffic_light_ctrl_timed.sv
// Highway/side-road intersection controller: Moore FSM with a saturating dwell counter.
// Define PED_WALK_EN to add the pedestrian request input and walk lamp output.
module traffic_light_ctrl_timed #(
    parameter int HWY_MIN    = 16,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int SIDE_MIN   = 4,
    parameter int SIDE_MAX   = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       X,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] hwy,
    output logic [1:0] contry,
    output logic [2:0] state_o
);

    localparam int MAX_HS    = (HWY_MIN > SIDE_MAX) ? HWY_MIN : SIDE_MAX;
    localparam int MAX_YA    = (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
    localparam int MAX_YS    = (MAX_YA > SIDE_MIN) ? MAX_YA : SIDE_MIN;
    localparam int DWELL_MAX = (MAX_HS > MAX_YS) ? MAX_HS : MAX_YS;
    localparam int CNT_W     = $clog2(DWELL_MAX) + 1;

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } lamp_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lamp_t            hwy_q, hwy_d, contry_q, contry_d;
    logic             pending;

    // A dwell of D cycles is complete once the counter shows D-1.
    function automatic logic reached(input logic [CNT_W-1:0] cnt, input int dwell);
        return cnt >= CNT_W'(dwell - 1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_HG:  if (reached(cnt_q, HWY_MIN) && (X || pending)) state_d = S_HY;
            S_HY:  if (reached(cnt_q, YELLOW_CYC)) state_d = S_AR1;
            S_AR1: if (reached(cnt_q, ALLRED_CYC)) state_d = S_SG;
            S_SG:  if ((reached(cnt_q, SIDE_MIN) && !X) || reached(cnt_q, SIDE_MAX)) state_d = S_SY;
            S_SY:  if (reached(cnt_q, YELLOW_CYC)) state_d = S_AR2;
            S_AR2: if (reached(cnt_q, ALLRED_CYC)) state_d = S_HG;
            default: state_d = S_HG;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (&cnt_q)        cnt_d = cnt_q;
        else                    cnt_d = cnt_q + 1'b1;

        // Lamps are decoded from the next state so they switch on the same edge as the state.
        hwy_d    = RED;
        contry_d = RED;
        case (state_d)
            S_HG:    hwy_d    = GREEN;
            S_HY:    hwy_d    = YELLOW;
            S_SG:    contry_d = GREEN;
            S_SY:    contry_d = YELLOW;
            default: ;
        endcase
    end

`ifdef PED_WALK_EN
    logic pending_q, pending_d, walk_q, walk_d;

    always_comb begin
        // A press on the very edge that enters S_SG is kept for the next sequence.
        pending_d = ped_req | (pending_q & ~((state_d == S_SG) && (state_q != S_SG)));
        walk_d    = (state_d == S_SG);
    end

    assign pending = pending_q;
    assign walk    = walk_q;
`else
    assign pending = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_HG;
            cnt_q     <= '0;
            hwy_q     <= GREEN;
            contry_q  <= RED;
`ifdef PED_WALK_EN
            pending_q <= 1'b0;
            walk_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hwy_q     <= hwy_d;
            contry_q  <= contry_d;
`ifdef PED_WALK_EN
            pending_q <= pending_d;
            walk_q    <= walk_d;
`endif
        end
    end

    assign hwy     = hwy_q;
    assign contry  = contry_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Self-checking bench for traffic_light_ctrl_timed against a phase/duration reference model.
// Pedestrian scenario is compiled in when PED_WALK_EN is defined.
module tb_traffic_light_ctrl_timed;

    localparam int HWY_MIN    = 8;
    localparam int YELLOW_CYC = 3;
    localparam int ALLRED_CYC = 2;
    localparam int SIDE_MIN   = 4;
    localparam int SIDE_MAX   = 10;

`ifdef PED_WALK_EN
    localparam bit PED_EN = 1'b1;
    logic ped_req;
    logic walk;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       x;
    logic [1:0] hwy;
    logic [1:0] contry;
    logic [2:0] state_o;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: phase index 0..5 around the ring and cycles spent in it.
    int m_phase;
    int m_time;
    bit m_pend;

    traffic_light_ctrl_timed #(
        .HWY_MIN(HWY_MIN), .YELLOW_CYC(YELLOW_CYC), .ALLRED_CYC(ALLRED_CYC),
        .SIDE_MIN(SIDE_MIN), .SIDE_MAX(SIDE_MAX)
    ) dut (
        .clk(clk),
        .clr(clr),
        .X(x),
`ifdef PED_WALK_EN
        .ped_req(ped_req),
        .walk(walk),
`endif
        .hwy(hwy),
        .contry(contry),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic int dwell(input int ph);
        case (ph)
            0:       return HWY_MIN;
            1, 4:    return YELLOW_CYC;
            2, 5:    return ALLRED_CYC;
            3:       return SIDE_MIN;
            default: return 1;
        endcase
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [1:0] h;
        logic [1:0] c;
        h = (m_phase == 0) ? 2'b10 : (m_phase == 1) ? 2'b01 : 2'b00;
        c = (m_phase == 3) ? 2'b10 : (m_phase == 4) ? 2'b01 : 2'b00;
        return {3'(m_phase), h, c};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_time  = 0;
        m_pend  = 1'b0;
    endtask

    task automatic model_step(input logic x_i, input logic ped_i);
        bit leave;
        int held;
        held  = m_time + 1;
        leave = held >= dwell(m_phase);
        if (m_phase == 0) leave = leave && (x_i || m_pend);
        if (m_phase == 3) leave = (leave && !x_i) || (held >= SIDE_MAX);
        m_pend = PED_EN && (ped_i || (m_pend && !(leave && m_phase == 2)));
        if (leave) begin
            m_phase = (m_phase + 1) % 6;
            m_time  = 0;
        end else begin
            m_time++;
        end
    endtask

    // Drive inputs for the current cycle, take one edge, advance the model, settle.
    task automatic tick(input logic x_i, input logic ped_i);
        x = x_i;
`ifdef PED_WALK_EN
        ped_req = ped_i;
`endif
        @(posedge clk);
        model_step(x_i, ped_i);
        #1;
    endtask

    task automatic apply_reset();
        clr = 1'b1;
        model_reset();
        @(posedge clk);
        #4;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({state_o, hwy, contry} !== 7'b000_10_00)
            $display("FAIL reset_idle: got %b expected %b", {state_o, hwy, contry}, 7'b000_10_00);
        else n_pass++;
        for (int i = 0; i < 40 && m_phase != 3; i++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if ({state_o, hwy, contry} !== exp_vec())
                $display("FAIL reset_walkup: got %b expected %b", {state_o, hwy, contry}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (state_o !== 3'd3) $display("FAIL reset_reach_sg: got state %0d expected 3", state_o);
        else n_pass++;
        #2;
        clr = 1'b1;
        #1;
        n_total++;
        if ({state_o, hwy, contry} !== 7'b000_10_00)
            $display("FAIL reset_async: got %b expected %b", {state_o, hwy, contry}, 7'b000_10_00);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({state_o, hwy, contry} !== 7'b000_10_00)
            $display("FAIL reset_held: got %b expected %b", {state_o, hwy, contry}, 7'b000_10_00);
        else n_pass++;
        #3;
        clr = 1'b0;
        model_reset();
        for (int e = 1; e <= HWY_MIN; e++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if (state_o !== ((e < HWY_MIN) ? 3'd0 : 3'd1))
                $display("FAIL reset_hwy_min: edge %0d got state %0d expected %0d", e, state_o,
                         (e < HWY_MIN) ? 0 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_hwy_min();
        int want;
        apply_reset();
        for (int e = 1; e <= 13; e++) begin
            tick((e == 1) ? 1'b0 : 1'b1, 1'b0);
            want = (e < 8) ? 0 : (e < 11) ? 1 : (e < 13) ? 2 : 3;
            n_total++;
            if (state_o !== 3'(want))
                $display("FAIL hwy_min_seq: edge %0d got state %0d expected %0d", e, state_o, want);
            else n_pass++;
            n_total++;
            if ({state_o, hwy, contry} !== exp_vec())
                $display("FAIL hwy_min_lamps: got %b expected %b", {state_o, hwy, contry}, exp_vec());
            else n_pass++;
        end
    endtask

    // Entered with contry already GREEN (first S_SG cycle observed).
    task automatic test_side_max();
        int sg_len;
        int tail [5];
        tail = '{4, 4, 5, 5, 0};
        sg_len = 1;
        for (int i = 0; i < 40 && contry === 2'b10; i++) begin
            tick(1'b1, 1'b0);
            if (contry === 2'b10) sg_len++;
            n_total++;
            if ({state_o, hwy, contry} !== exp_vec())
                $display("FAIL side_max_seq: got %b expected %b", {state_o, hwy, contry}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (sg_len != SIDE_MAX) $display("FAIL side_max_len: got %0d expected %0d", sg_len, SIDE_MAX);
        else n_pass++;
        n_total++;
        if (state_o !== 3'd4) $display("FAIL side_max_exit: got state %0d expected 4", state_o);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if (state_o !== 3'(tail[i]))
                $display("FAIL side_max_tail: step %0d got state %0d expected %0d", i, state_o, tail[i]);
            else n_pass++;
        end
    endtask

    task automatic test_side_min();
        int sg_len;
        for (int i = 0; i < 40 && contry !== 2'b10; i++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if ({state_o, hwy, contry} !== exp_vec())
                $display("FAIL side_min_walkup: got %b expected %b", {state_o, hwy, contry}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (contry !== 2'b10) $display("FAIL side_min_reach_sg: got contry %b expected 10", contry);
        else n_pass++;
        sg_len = 1;
        tick(1'b1, 1'b0);
        if (contry === 2'b10) sg_len++;
        for (int i = 0; i < 40 && contry === 2'b10; i++) begin
            tick(1'b0, 1'b0);
            if (contry === 2'b10) sg_len++;
        end
        n_total++;
        if (sg_len != SIDE_MIN) $display("FAIL side_min_len: got %0d expected %0d", sg_len, SIDE_MIN);
        else n_pass++;
        n_total++;
        if ({state_o, hwy, contry} !== 7'b100_00_01)
            $display("FAIL side_min_exit: got %b expected %b", {state_o, hwy, contry}, 7'b100_00_01);
        else n_pass++;
    endtask

    task automatic test_ignore_pulse();
        apply_reset();
        for (int i = 0; i < 40 && m_phase != 1; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40 && m_phase != 5; i++) begin
            tick(1'b0, 1'b0);
            n_total++;
            if ({state_o, hwy, contry} !== exp_vec())
                $display("FAIL pulse_seq: got %b expected %b", {state_o, hwy, contry}, exp_vec());
            else n_pass++;
        end
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
        n_total++;
        if ({state_o, hwy, contry} !== 7'b000_10_00)
            $display("FAIL pulse_stay_hg: got %b expected %b", {state_o, hwy, contry}, 7'b000_10_00);
        else n_pass++;
    endtask

`ifdef PED_WALK_EN
    task automatic test_ped_walk();
        int walk_cnt;
        apply_reset();
        for (int e = 1; e <= HWY_MIN; e++) begin
            tick(1'b0, (e == 3) ? 1'b1 : 1'b0);
            n_total++;
            if (state_o !== ((e < HWY_MIN) ? 3'd0 : 3'd1))
                $display("FAIL ped_hy_entry: edge %0d got state %0d", e, state_o);
            else n_pass++;
        end
        walk_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            if (walk === 1'b1) walk_cnt++;
            n_total++;
            if ({walk, state_o, hwy, contry} !== {1'(m_phase == 3), exp_vec()})
                $display("FAIL ped_seq: got %b expected %b", {walk, state_o, hwy, contry},
                         {1'(m_phase == 3), exp_vec()});
            else n_pass++;
        end
        n_total++;
        if (walk_cnt != SIDE_MIN) $display("FAIL ped_walk_len: got %0d expected %0d", walk_cnt, SIDE_MIN);
        else n_pass++;
        n_total++;
        if ({walk, state_o} !== 4'b0_000) $display("FAIL ped_back_hg: got %b expected 0000", {walk, state_o});
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic xr;
        logic pr;
        apply_reset();
        xr = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) xr = ~xr;
            pr = ($urandom_range(0, 24) == 0);
            tick(xr, pr);
            n_total++;
            if ({state_o, hwy, contry} !== exp_vec())
                $display("FAIL random_seq: cycle %0d got %b expected %b", i, {state_o, hwy, contry}, exp_vec());
            else n_pass++;
`ifdef PED_WALK_EN
            n_total++;
            if (walk !== 1'(m_phase == 3))
                $display("FAIL random_walk: cycle %0d got %b expected %b", i, walk, 1'(m_phase == 3));
            else n_pass++;
`endif
            if ($urandom_range(0, 199) == 0) begin
                #2;
                clr = 1'b1;
                model_reset();
                #1;
                n_total++;
                if ({state_o, hwy, contry} !== exp_vec())
                    $display("FAIL random_reset: got %b expected %b", {state_o, hwy, contry}, exp_vec());
                else n_pass++;
                #2;
                clr = 1'b0;
            end
        end
    endtask

    initial begin
        clr = 1'b1;
        x   = 1'b0;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif
        model_reset();
        #2;
        test_reset();
        test_hwy_min();
        test_side_max();
        test_side_min();
        test_ignore_pulse();
`ifdef PED_WALK_EN
        test_ped_walk();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
